// File: rtl/riscv_pkg.sv
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared types and constants for the instruction-fetch slice:
//            data/address width, the canonical NOP, the fetch FSM state type
//            and the FIFO entry layout (instruction word + its PC).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0 -- shown to ID whenever no instruction is available
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/if_fetch_if.sv
// ============================================================================
// Module   : if_fetch_if
// Purpose  : Bundles the fetch stage's three conversations:
//            - instruction-memory request/response (imem_*)
//            - redirect from EX (redirect, redirect_pc)
//            - instruction hand-off to ID (inst, inst_pc, inst_valid/ready)
// Modports : master - the fetch stage
//            slave  - its environment (memory, EX, ID)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface if_fetch_if;
  import riscv_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_valid;
  logic            inst_ready;

  modport master (
    output imem_req, imem_addr, inst, inst_pc, inst_valid,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst, inst_pc, inst_valid,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready
  );

endinterface

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module   : fetch_fifo
// Purpose  : DEPTH-entry FIFO of fetch_entry_t with synchronous flush.
//            Push and pop in the same cycle are accepted even when full.
// Ports    : clk, rst_n (async, active-low)
//            i_push/i_data, i_pop, i_flush (flush wins over push/pop)
//            o_head (valid when !o_empty), o_empty, o_count
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  input  wire logic                 i_push,
  input  fetch_entry_t              i_data,
  input  wire logic                 i_pop,
  input  wire logic                 i_flush,
  output fetch_entry_t              o_head,
  output logic                      o_empty,
  output logic [$clog2(DEPTH):0]    o_count
);

  localparam int             AW      = $clog2(DEPTH);
  localparam logic [AW:0]    C_DEPTH = DEPTH[AW:0];

  fetch_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_pop  = i_pop && (r_count != '0);
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign w_do_push = i_push && ((r_count != C_DEPTH) || w_do_pop);

  // Storage needs no reset: the pointers decide what is visible.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/if_fetch.sv
// ============================================================================
// Module   : if_fetch
// Purpose  : Instruction-fetch stage. Holds the PC, issues one word request
//            at a time to instruction memory, buffers returned words in a
//            small FIFO and hands them to ID over valid/ready. A redirect
//            flushes the FIFO and discards any response still in flight.
// Ports    : clk, rst_n (async, active-low)
//            bus (if_fetch_if.master): imem_*, redirect*, inst*
//            fetch_cnt[31:0], flush_cnt[15:0] (only with IF_PERF_CNT_EN)
// Config   : IF_PERF_CNT_EN - adds saturating counters of pushed words and
//            redirects; functional behaviour is the same either way.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  if_fetch_if.master  bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [15:0] flush_cnt
`endif
);

  localparam int              AW           = $clog2(DEPTH);
  localparam logic [XLEN-1:0] C_PC_STEP    = 'd4;
  localparam logic [XLEN-1:0] C_ALIGN_MASK = 'd3;

  fetch_state_t  r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_pc;

  fetch_entry_t  w_head;
  fetch_entry_t  w_push_data;
  logic          w_empty;
  logic [AW:0]   w_count;
  logic [AW+1:0] w_inflight;
  logic          w_outstanding;
  logic          w_grant;
  logic          w_push;
  logic          w_pop;
  logic          w_busy_after;

  // Credit rule: a request is only issued if its response is sure of a slot.
  // The DROP state doubles as the drop flag for a response to be discarded.
  assign w_outstanding = (r_state == WAIT) || (r_state == DROP);
  assign w_inflight    = {1'b0, w_count} + (AW+2)'(w_outstanding);
  assign bus.imem_req  = (r_state == REQ) && (w_inflight < (AW+2)'(DEPTH));
  assign bus.imem_addr = r_pc;

  assign w_grant = bus.imem_req && bus.imem_gnt;
  // Responses outside WAIT (DROP, or late ones after a reset) never enter.
  assign w_push  = (r_state == WAIT) && bus.imem_rvalid && !bus.redirect;
  assign w_pop   = bus.inst_valid && bus.inst_ready;

  assign w_push_data.inst = bus.imem_rdata;
  assign w_push_data.pc   = r_req_pc;

  // Will a response still be owed after this edge? Decides DROP vs REQ on
  // a redirect, covering a grant that coincides with the redirect.
  assign w_busy_after = (w_outstanding && !bus.imem_rvalid) || w_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_pc     <= RESET_PC;
      r_req_pc <= RESET_PC;
    end else if (bus.redirect) begin
      r_pc    <= bus.redirect_pc & ~C_ALIGN_MASK;
      r_state <= w_busy_after ? DROP : REQ;
    end else begin
      case (r_state)
        IDLE: r_state <= REQ;
        REQ: begin
          if (w_grant) begin
            r_state  <= WAIT;
            r_req_pc <= r_pc;
            r_pc     <= r_pc + C_PC_STEP;
          end
        end
        WAIT: if (bus.imem_rvalid) r_state <= REQ;
        DROP: if (bus.imem_rvalid) r_state <= REQ;
        default: r_state <= IDLE;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .i_flush (bus.redirect),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign bus.inst_valid = !w_empty;
  assign bus.inst       = w_empty ? NOP_INST : w_head.inst;
  assign bus.inst_pc    = w_empty ? '0 : w_head.pc;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_push && (r_fetch_cnt != '1))       r_fetch_cnt <= r_fetch_cnt + 1'b1;
      if (bus.redirect && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_fetch.sv
// ============================================================================
// Module   : tb_if_fetch
// Purpose  : Self-checking bench for if_fetch. A memory/EX/ID driver issues
//            randomized grants, response delays, redirects and back-pressure
//            and pushes every word that should reach ID into a queue; a
//            separate monitor pops that queue on each accepted instruction.
//            The reference is the program-order rule: words come out in grant
//            order, and a redirect kills every word granted or buffered
//            before it, restarting the fetch stream at the aligned target.
// Config   : IF_PERF_CNT_EN - also checks the performance counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  if_fetch_if bus ();

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [15:0] flush_cnt;
`endif

  if_fetch #(
    .RESET_PC (RST_PC),
    .DEPTH    (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt (fetch_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // scoreboard
  exp_t exp_q[$];

  // environment model
  int unsigned p_gnt = 100, p_ready = 100, p_redir = 0, max_delay = 0;
  logic        force_redirect = 1'b0;
  logic [31:0] force_target   = '0;
  logic        pending = 1'b0, stale = 1'b0, late = 1'b0;
  logic [31:0] pend_addr = '0;
  int unsigned pend_delay = 0;
  logic [31:0] exp_pc = RST_PC;
  logic        prev_req_hold = 1'b0, prev_redirect = 1'b0;
  logic [31:0] prev_addr = '0;
  logic        first_rsp_seen = 1'b0, lat_check = 1'b0;
  int unsigned reset_epoch = 0;
  int unsigned n_push = 0, n_flush = 0;

  // monitor state
  logic        mon_hold  = 1'b0;
  logic [63:0] hold_word = '0;
  int unsigned mon_epoch = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1359_0913;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_imem_req"},   64'(bus.imem_req),   64'(1'b0));
    check({tag, "_imem_addr"},  64'(bus.imem_addr),  64'(RST_PC));
    check({tag, "_inst_valid"}, 64'(bus.inst_valid), 64'(1'b0));
    check({tag, "_inst"},       64'(bus.inst),       64'(NOP));
    check({tag, "_inst_pc"},    64'(bus.inst_pc),    64'(32'h0));
  endtask

  // One clock of memory / EX / ID behaviour. Outputs are sampled 1 ns after
  // the rising edge, then this cycle's inputs are driven.
  task automatic step();
    logic        req;
    logic [31:0] addr;
    logic        redir;
    logic [31:0] tgt;
    @(posedge clk);
    #1;
    req  = bus.imem_req;
    addr = bus.imem_addr;
    if (prev_redirect) check("flush_empties_fifo", 64'(bus.inst_valid), 64'(1'b0));
    if (prev_req_hold) begin
      check("req_held_until_gnt",  64'(req),  64'(1'b1));
      check("addr_held_until_gnt", 64'(addr), 64'(prev_addr));
    end
    if (lat_check) begin
      check("valid_one_cycle_after_rvalid", 64'(bus.inst_valid), 64'(1'b1));
      lat_check = 1'b0;
    end

    redir = force_redirect || ($urandom_range(99) < p_redir);
    tgt   = force_redirect ? force_target : $urandom;
    force_redirect = 1'b0;

    // response channel
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = $urandom;
    if (pending) begin
      if (pend_delay == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(pend_addr);
        if (!stale && !redir) begin
          exp_q.push_back('{pc: pend_addr, inst: mem_word(pend_addr)});
          n_push++;
          if (!first_rsp_seen) begin
            first_rsp_seen = 1'b1;
            check("valid_low_at_first_rvalid", 64'(bus.inst_valid), 64'(1'b0));
            lat_check = 1'b1;
          end
        end
        pending = 1'b0;
        late    = 1'b0;
      end else begin
        pend_delay--;
      end
    end
    if (pending && !late) check("single_outstanding", 64'(req), 64'(1'b0));

    // request channel
    bus.imem_gnt = 1'b0;
    if (req) begin
      check("fetch_addr", 64'(addr), 64'(exp_pc));
      if (!pending && ($urandom_range(99) < p_gnt)) begin
        bus.imem_gnt = 1'b1;
        pending    = 1'b1;
        late       = 1'b0;
        stale      = redir;
        pend_addr  = addr;
        pend_delay = $urandom_range(max_delay);
        exp_pc     = addr + 32'd4;
      end
    end

    // redirect: everything older than it is dead
    bus.redirect    = redir;
    bus.redirect_pc = tgt;
    if (redir) begin
      exp_pc = tgt & ~32'h3;
      exp_q.delete();
      if (pending) stale = 1'b1;
      n_flush++;
    end

    bus.inst_ready = ($urandom_range(99) < p_ready);
    prev_req_hold  = req && !bus.imem_gnt && !redir;
    prev_addr      = addr;
    prev_redirect  = redir;
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #1;
    bus.redirect    = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.inst_ready  = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    rst_n = 1'b1;
    exp_q.delete();
    exp_pc = RST_PC;
    if (pending) begin
      stale = 1'b1;
      late  = 1'b1;
    end
    prev_req_hold = 1'b0;
    prev_redirect = 1'b0;
    lat_check     = 1'b0;
    reset_epoch++;
    n_push  = 0;
    n_flush = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // monitor: consumes the scoreboard on every accepted instruction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mon_hold && (mon_epoch == reset_epoch)) begin
          check("inst_held_valid", 64'(bus.inst_valid), 64'(1'b1));
          check("inst_held_word", {bus.inst_pc, bus.inst}, hold_word);
        end
        if (bus.inst_valid && bus.inst_ready && !bus.redirect) begin
          check("inst_expected", 64'(exp_q.size() != 0), 64'(1'b1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("inst_pc", 64'(bus.inst_pc), 64'(e.pc));
            check("inst_word", 64'(bus.inst), 64'(e.inst));
          end
        end
        mon_hold  = bus.inst_valid && !bus.inst_ready && !bus.redirect;
        hold_word = {bus.inst_pc, bus.inst};
        mon_epoch = reset_epoch;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.inst_ready  = 1'b0;

    #12 check_reset_values("reset");
    @(negedge clk) rst_n = 1'b1;

    // streaming with an immediately granting memory
    p_gnt = 100; p_ready = 100; max_delay = 0;
    run(12);

    // back-pressure fills the FIFO and stops requests
    p_ready = 0;
    run(10);
    check("full_stops_req", 64'(bus.imem_req),   64'(1'b0));
    check("full_inst_valid", 64'(bus.inst_valid), 64'(1'b1));
    p_ready = 100;
    run(10);

    // redirect while a response is outstanding
    max_delay = 3;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (pending && (pend_delay > 0)) begin ok = 1'b1; break; end
    end
    check("reach_wait_for_redirect", 64'(ok), 64'(1'b1));
    force_redirect = 1'b1; force_target = 32'h0000_0103;
    run(12);

    // redirect coinciding with rvalid and a pop
    max_delay = 0; p_ready = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (pending && (pend_delay == 0) && bus.inst_valid) begin ok = 1'b1; break; end
    end
    check("reach_rvalid_pop_redirect", 64'(ok), 64'(1'b1));
    p_ready = 100;
    force_redirect = 1'b1; force_target = $urandom;
    run(10);

    // PC wrap through the top of the address space
    force_redirect = 1'b1; force_target = 32'hFFFF_FFF9;
    run(12);

    // asynchronous reset while waiting on memory; the late response is junk
    max_delay = 3;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (pending && (pend_delay >= 2)) begin ok = 1'b1; break; end
    end
    check("reach_wait_for_reset", 64'(ok), 64'(1'b1));
    reset_pulse();
    run(12);

    // randomized traffic
    p_gnt = 60; p_ready = 60; p_redir = 5; max_delay = 3;
    run(400);

    // quiesce and drain
    p_gnt = 0; p_redir = 0; p_ready = 100;
    for (int i = 0; i < 60; i++) begin
      if ((exp_q.size() == 0) && !pending) break;
      step();
    end
    step();
    check("drain_scoreboard", 64'(exp_q.size()), 64'(0));
`ifdef IF_PERF_CNT_EN
    check("fetch_cnt", 64'(fetch_cnt), 64'(n_push));
    check("flush_cnt", 64'(flush_cnt), 64'(n_flush));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
